// File: rtl/dff_write_arbiter_if.sv
// Bundle of requester handshake and DFF-bank write signals for dff_write_arbiter.
// The master side is the requesters plus the register bank; the slave side is the arbiter.
interface dff_write_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) ();
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       req_ready;
    logic                   reg_en;
    logic [WIDTH-1:0]       reg_d;
    logic [ID_W-1:0]        grant_id;
    logic                   busy;

    modport master (
        output req_valid, req_data,
        input  req_ready, reg_en, reg_d, grant_id, busy
    );

    modport slave (
        input  req_valid, req_data,
        output req_ready, reg_en, reg_d, grant_id, busy
    );
endinterface

// File: rtl/dff_write_arbiter.sv
// Round-robin write arbiter feeding the en/d inputs of a shared DFF bank,
// with a one-cycle write pulse followed by a programmable idle gap.
module dff_write_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int HOLD  = 2
) (
    input  logic               clk,
    input  logic               rst,
    dff_write_arbiter_if.slave bus
);
    localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD = (HOLD > 0) ? CNT_W'(HOLD - 1) : '0;
    localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(N_REQ - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [ID_W-1:0]  grant_q, grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             reg_en_q, reg_en_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] reg_d_q, reg_d_d;

    logic [WIDTH-1:0] data_arr [N_REQ];
    logic [N_REQ-1:0] upper_req;
    logic [ID_W-1:0]  sel_idx;
    logic             sel_found;

    // upper_req keeps only requests at or above the pointer, so they win the scan before wrapping
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
        assign data_arr[gi]       = bus.req_data[gi*WIDTH +: WIDTH];
        assign upper_req[gi]      = bus.req_valid[gi] && (gi >= int'(ptr_q));
        assign bus.req_ready[gi]  = !rst && (state_q == ST_IDLE) && sel_found
                                    && (sel_idx == ID_W'(gi));
    end

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                sel_found = 1'b1;
                sel_idx   = ID_W'(i);
            end
        end
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (upper_req[i]) begin
                sel_idx = ID_W'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        cnt_d    = cnt_q;
        reg_en_d = 1'b0;
        busy_d   = busy_q;
        reg_d_d  = reg_d_q;
        case (state_q)
            ST_IDLE: begin
                if (sel_found) begin
                    reg_d_d  = data_arr[sel_idx];
                    grant_d  = sel_idx;
                    ptr_d    = (sel_idx == LAST_ID) ? '0 : sel_idx + 1'b1;
                    reg_en_d = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (HOLD > 0) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LOAD;
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            grant_q  <= '0;
            cnt_q    <= '0;
            reg_en_q <= 1'b0;
            busy_q   <= 1'b0;
            reg_d_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
            reg_en_q <= reg_en_d;
            busy_q   <= busy_d;
            reg_d_q  <= reg_d_d;
        end
    end

    assign bus.reg_en   = reg_en_q;
    assign bus.reg_d    = reg_d_q;
    assign bus.grant_id = grant_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_dff_write_arbiter.sv
// Bench for dff_write_arbiter: a HOLD=2 and a HOLD=0 instance, each checked every cycle
// against a cycle-timeline model, plus directed scenarios with literal expectations.
module tb_dff_write_arbiter;
    logic clk;
    logic rst_a;
    logic rst_b;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // model state per instance (0: HOLD=2, 1: HOLD=0)
    int         m_ptr    [2];
    int         m_gid    [2];
    logic [7:0] m_d      [2];
    int         last_acc [2];
    int         next_ok  [2];
    bit         armed    [2];

    int g_q[$];
    int d_q[$];
    int c_q[$];

    dff_write_arbiter_if #(.N_REQ(4), .WIDTH(8)) ifa ();
    dff_write_arbiter_if #(.N_REQ(4), .WIDTH(8)) ifb ();

    dff_write_arbiter #(.N_REQ(4), .WIDTH(8), .HOLD(2)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (ifa)
    );

    dff_write_arbiter #(.N_REQ(4), .WIDTH(8), .HOLD(0)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Timeline model: an accept at cycle T gives en at T+1, busy over (T, T+2+hold),
    // and the next accept no earlier than T+2+hold.
    task automatic model_step(input int k, input int hold, input logic rst,
                              input logic [3:0] v, input logic [31:0] data,
                              input logic [3:0] rdy, input logic en, input logic [7:0] d,
                              input logic [1:0] gid, input logic busy);
        int         sel;
        int         idx;
        logic [3:0] exp_rdy;
        logic       exp_en;
        logic       exp_busy;
        sel     = -1;
        exp_rdy = 4'h0;
        if (!rst && cyc >= next_ok[k]) begin
            for (int j = 0; j < 4; j++) begin
                idx = (m_ptr[k] + j) % 4;
                if (sel < 0 && v[idx]) sel = idx;
            end
        end
        if (sel >= 0) exp_rdy[sel] = 1'b1;
        exp_en   = (cyc == last_acc[k] + 1);
        exp_busy = (cyc > last_acc[k]) && (cyc < last_acc[k] + 2 + hold);
        if (armed[k]) begin
            check($sformatf("model%0d_ready", k), rdy, exp_rdy);
            check($sformatf("model%0d_en", k), en, exp_en);
            check($sformatf("model%0d_d", k), d, m_d[k]);
            check($sformatf("model%0d_gid", k), gid, m_gid[k]);
            check($sformatf("model%0d_busy", k), busy, exp_busy);
            if (en) $display("dut%0d write gid=%0d d=%02h cycle=%0d", k, gid, d, cyc);
        end
        if (rst) begin
            m_ptr[k]    = 0;
            m_gid[k]    = 0;
            m_d[k]      = 8'h00;
            last_acc[k] = -1000;
            next_ok[k]  = 0;
            armed[k]    = 1'b1;
        end else if (sel >= 0) begin
            m_d[k]      = data[sel*8 +: 8];
            m_gid[k]    = sel;
            m_ptr[k]    = (sel + 1) % 4;
            last_acc[k] = cyc;
            next_ok[k]  = cyc + 2 + hold;
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            armed[k]    = 1'b0;
            last_acc[k] = -1000;
            next_ok[k]  = 0;
            m_ptr[k]    = 0;
            m_gid[k]    = 0;
            m_d[k]      = 8'h00;
        end
        forever begin
            @(negedge clk);
            model_step(0, 2, rst_a, ifa.req_valid, ifa.req_data, ifa.req_ready,
                       ifa.reg_en, ifa.reg_d, ifa.grant_id, ifa.busy);
            model_step(1, 0, rst_b, ifb.req_valid, ifb.req_data, ifb.req_ready,
                       ifb.reg_en, ifb.reg_d, ifb.grant_id, ifb.busy);
            cyc++;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic capture_a(input int n);
        g_q.delete(); d_q.delete(); c_q.delete();
        for (int o = 0; o < n; o++) begin
            sample();
            if (ifa.reg_en) begin
                g_q.push_back(int'(ifa.grant_id));
                d_q.push_back(int'(ifa.reg_d));
                c_q.push_back(cyc);
            end
            next_cycle();
        end
    endtask

    initial begin
        int exp3 [5];
        int exp4 [4];
        int e;
        exp3 = '{0, 1, 2, 3, 0};
        exp4 = '{0, 3, 0, 3};

        // reset with all requesters valid
        rst_a = 1'b1;
        rst_b = 1'b1;
        ifa.req_valid = 4'hF;
        ifa.req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        ifb.req_valid = 4'hF;
        ifb.req_data  = {8'h33, 8'h32, 8'h31, 8'h30};
        next_cycle();
        sample();
        check("t1_ready", ifa.req_ready, 4'h0);
        check("t1_en", ifa.reg_en, 1'b0);
        check("t1_d", ifa.reg_d, 8'h00);
        check("t1_busy", ifa.busy, 1'b0);
        check("t1_gid", ifa.grant_id, 2'd0);

        // single write from requester 2
        next_cycle();
        rst_a = 1'b0;
        ifa.req_valid = 4'b0100;
        ifa.req_data[23:16] = 8'hA5;
        sample();
        check("t2_ready", ifa.req_ready, 4'b0100);
        next_cycle();
        sample();
        check("t2_en", ifa.reg_en, 1'b1);
        check("t2_d", ifa.reg_d, 8'hA5);
        check("t2_gid", ifa.grant_id, 2'd2);
        check("t2_busy", ifa.busy, 1'b1);
        next_cycle();
        ifa.req_valid = 4'b0000;
        sample();
        next_cycle();
        sample();
        check("t2_busy_hold", ifa.busy, 1'b1);
        next_cycle();
        sample();
        check("t2_busy_low", ifa.busy, 1'b0);
        check("t2_d_held", ifa.reg_d, 8'hA5);
        check("t2_gid_held", ifa.grant_id, 2'd2);

        // full contention, pointer rotates and wraps
        next_cycle();
        rst_a = 1'b1;
        ifa.req_valid = 4'hF;
        ifa.req_data[23:16] = 8'h12;
        next_cycle();
        rst_a = 1'b0;
        capture_a(18);
        check("t3_count", g_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t3_gid%0d", i), (i < g_q.size()) ? g_q[i] : -1, exp3[i]);
            check($sformatf("t3_d%0d", i), (i < d_q.size()) ? d_q[i] : -1, 8'h10 + exp3[i]);
            if (i > 0) begin
                e = (i < c_q.size()) ? c_q[i] - c_q[i-1] : -1;
                check($sformatf("t3_gap%0d", i), e, 4);
            end
        end

        // fairness between requesters 0 and 3
        rst_a = 1'b1;
        ifa.req_valid = 4'b1001;
        ifa.req_data  = {8'h23, 8'h12, 8'h11, 8'h20};
        next_cycle();
        rst_a = 1'b0;
        capture_a(14);
        check("t4_count", g_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t4_gid%0d", i), (i < g_q.size()) ? g_q[i] : -1, exp4[i]);
            check($sformatf("t4_d%0d", i), (i < d_q.size()) ? d_q[i] : -1,
                  (exp4[i] == 0) ? 8'h20 : 8'h23);
        end

        // reset during the write pulse
        rst_a = 1'b1;
        ifa.req_valid = 4'hF;
        ifa.req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        next_cycle();
        rst_a = 1'b0;
        sample();
        check("t5_ready", ifa.req_ready, 4'b0001);
        next_cycle();
        rst_a = 1'b1;
        ifa.req_valid = 4'h0;
        sample();
        check("t5_en_before", ifa.reg_en, 1'b1);
        next_cycle();
        rst_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sample();
            check($sformatf("t5_en_off%0d", i), ifa.reg_en, 1'b0);
            check($sformatf("t5_busy_off%0d", i), ifa.busy, 1'b0);
            next_cycle();
        end
        ifa.req_valid = 4'hF;
        sample();
        check("t5_ptr_zero", ifa.req_ready, 4'b0001);
        next_cycle();
        sample();
        check("t5_en_new", ifa.reg_en, 1'b1);
        check("t5_gid_new", ifa.grant_id, 2'd0);
        check("t5_d_new", ifa.reg_d, 8'h10);
        next_cycle();

        // HOLD=0 instance: a pulse every second cycle
        rst_b = 1'b0;
        g_q.delete();
        for (int o = 0; o < 10; o++) begin
            sample();
            check($sformatf("t6_en%0d", o), ifb.reg_en, (o % 2) == 1);
            check($sformatf("t6_busy%0d", o), ifb.busy, (o % 2) == 1);
            if (ifb.reg_en) g_q.push_back(int'(ifb.grant_id));
            next_cycle();
        end
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t6_gid%0d", i), (i < g_q.size()) ? g_q[i] : -1, exp3[i]);
        end

        next_cycle();
        next_cycle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
